// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU arbiter: ctl/flag bit positions,
// FSM state encoding and the default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam int CTL_FNCLASS = 0;
  localparam int CTL_LOGICFN = 1;
  localparam int CTL_ALUFN   = 2;
  localparam int CTL_ALUIMM  = 3;

  localparam int FLAG_OVERFLOW = 0;
  localparam int FLAG_SIGN     = 1;
  localparam int FLAG_CARRY    = 2;
  localparam int FLAG_ZERO     = 3;

  typedef enum logic [1:0] {
    ALU_ARB_IDLE = 2'd0,
    ALU_ARB_EXEC = 2'd1,
    ALU_ARB_RESP = 2'd2
  } alu_arb_state_e;

endpackage

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone valid always wins, a tie goes to prio_i.
module rr_arbiter2 (
  input  logic [1:0] valid_i,
  input  logic       prio_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    if (valid_i == 2'b11) begin
      gnt_o = prio_i ? 2'b10 : 2'b01;
    end else begin
      gnt_o = valid_i;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: registered ALU inputs,
// one ALU slot in flight, and a per-port response buffer held until accepted.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_rs,
  input  logic [WIDTH-1:0] req0_rt,
  input  logic [WIDTH-1:0] req0_imm,
  input  logic [3:0]       req0_ctl,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_rs,
  input  logic [WIDTH-1:0] req1_rt,
  input  logic [WIDTH-1:0] req1_imm,
  input  logic [3:0]       req1_ctl,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic [3:0]       rsp0_flags,

  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic [3:0]       rsp1_flags,

  output logic [WIDTH-1:0] alu_rs,
  output logic [WIDTH-1:0] alu_rt,
  output logic [WIDTH-1:0] alu_imm,
  output logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,

  output logic             busy
);

  alu_arb_state_e   state_q, state_d;
  logic             prio_q, prio_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] alu_rs_q, alu_rs_d;
  logic [WIDTH-1:0] alu_rt_q, alu_rt_d;
  logic [WIDTH-1:0] alu_imm_q, alu_imm_d;
  logic [3:0]       alu_ctl_q, alu_ctl_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q [2];
  logic [WIDTH-1:0] rsp_result_d [2];
  logic [3:0]       rsp_flags_q [2];
  logic [3:0]       rsp_flags_d [2];

  logic [1:0] gnt;
  logic [1:0] req_ready;
  logic [1:0] rsp_ready;
  logic       idle;

  rr_arbiter2 u_rr (
    .valid_i ({req1_valid, req0_valid}),
    .prio_i  (prio_q),
    .gnt_o   (gnt)
  );

  assign idle      = (state_q == ALU_ARB_IDLE);
  assign req_ready = idle ? gnt : 2'b00;
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    owner_d      = owner_q;
    alu_rs_d     = alu_rs_q;
    alu_rt_d     = alu_rt_q;
    alu_imm_d    = alu_imm_q;
    alu_ctl_d    = alu_ctl_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;

    case (state_q)
      ALU_ARB_IDLE: begin
        // ready is a subset of valid, so any ready bit is a handshake
        if (|req_ready) begin
          owner_d   = req_ready[1];
          prio_d    = ~req_ready[1];
          alu_rs_d  = req_ready[1] ? req1_rs  : req0_rs;
          alu_rt_d  = req_ready[1] ? req1_rt  : req0_rt;
          alu_imm_d = req_ready[1] ? req1_imm : req0_imm;
          alu_ctl_d = req_ready[1] ? req1_ctl : req0_ctl;
          state_d   = ALU_ARB_EXEC;
        end
      end
      ALU_ARB_EXEC: begin
        rsp_valid_d[owner_q]  = 1'b1;
        rsp_result_d[owner_q] = alu_result;
        rsp_flags_d[owner_q]  = alu_flags;
        state_d               = ALU_ARB_RESP;
      end
      ALU_ARB_RESP: begin
        // clearing the buffer on accept keeps idle outputs at zero
        if (rsp_ready[owner_q]) begin
          rsp_valid_d[owner_q]  = 1'b0;
          rsp_result_d[owner_q] = '0;
          rsp_flags_d[owner_q]  = '0;
          state_d               = ALU_ARB_IDLE;
        end
      end
      default: state_d = ALU_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ALU_ARB_IDLE;
      prio_q          <= 1'b0;
      owner_q         <= 1'b0;
      alu_rs_q        <= '0;
      alu_rt_q        <= '0;
      alu_imm_q       <= '0;
      alu_ctl_q       <= '0;
      rsp_valid_q     <= '0;
      rsp_result_q[0] <= '0;
      rsp_result_q[1] <= '0;
      rsp_flags_q[0]  <= '0;
      rsp_flags_q[1]  <= '0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      owner_q      <= owner_d;
      alu_rs_q     <= alu_rs_d;
      alu_rt_q     <= alu_rt_d;
      alu_imm_q    <= alu_imm_d;
      alu_ctl_q    <= alu_ctl_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  assign req0_ready  = req_ready[0];
  assign req1_ready  = req_ready[1];
  assign rsp0_valid  = rsp_valid_q[0];
  assign rsp1_valid  = rsp_valid_q[1];
  assign rsp0_result = rsp_result_q[0];
  assign rsp1_result = rsp_result_q[1];
  assign rsp0_flags  = rsp_flags_q[0];
  assign rsp1_flags  = rsp_flags_q[1];
  assign alu_rs      = alu_rs_q;
  assign alu_rt      = alu_rt_q;
  assign alu_imm     = alu_imm_q;
  assign alu_ctl     = alu_ctl_q;
  assign busy        = !idle;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU datapath between two requesters, for example the integer pipeline (port 0) and a multi-cycle microsequencer (port 1). Grants are round-robin with a valid/ready handshake on each request port. The block drives the ALU's operand and control inputs from registers and captures result and flags into a per-port response buffer. Each response is held until the requester accepts it.

## Interface
- `WIDTH`, 32, operand and result width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `reqN_valid`  in  1  requester N (N = 0, 1) presents an operation.
- `reqN_ready`  out  1  operation on port N is accepted this cycle.
- `reqN_rs`, `reqN_rt`, `reqN_imm`  in  WIDTH each  operands for port N.
- `reqN_ctl`  in  4  control bits for port N: [3] ALUimm, [2] ALUfn, [1] logicfn, [0] fnClass.
- `rspN_valid`  out  1  response buffer for port N holds a result.
- `rspN_ready`  in  1  requester N accepts the response.
- `rspN_result`  out  WIDTH  result for port N.
- `rspN_flags`  out  4  flags for port N: [3] zero, [2] carry, [1] sign, [0] overflow.
- `alu_rs`, `alu_rt`, `alu_imm`  out  WIDTH each  registered operands to the ALU.
- `alu_ctl`  out  4  registered control bits to the ALU, same bit order as `reqN_ctl`.
- `alu_result`  in  WIDTH  ALU result.
- `alu_flags`  in  4  ALU flags, same bit order as `rspN_flags`.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Pick a winner among the ports with `reqN_valid` high.
  - If both are valid, the port indicated by the priority pointer `prio` wins.
  - Assert the winner's `reqN_ready` in the same cycle (combinational; it depends on valid). The losing port's ready stays low.
  - On the handshake: latch the operands and ctl into the `alu_*` registers, record `owner` = winner, set `prio` = other port, go to EXEC.
- EXEC: capture `alu_result`/`alu_flags` into the owner's response buffer, set `rsp<owner>_valid`, go to RESP.
- RESP: hold the buffer stable while `rsp<owner>_valid & !rsp<owner>_ready`. On the handshake, clear valid and go to IDLE.
- `prio` moves only on a grant. A single valid requester always wins, regardless of `prio`.
- The `alu_*` registers hold their last value outside grants, so the ALU inputs never glitch.
- The non-owner's response outputs remain 0/invalid.
- Reset mid-operation: state returns to IDLE and any in-flight operation and unaccepted response are dropped. Requesters must reissue.
- Reset values: state IDLE, `prio` 0, `owner` 0, all `alu_*` 0, all `rsp*_valid` 0, results and flags 0, `busy` 0, `reqN_ready` 0.

## Timing
- Grant in cycle T. The ALU sees the new operands from T+1. The response is valid from T+2.
- Minimum service time is 3 cycles per operation: IDLE, EXEC, RESP accepted immediately.
- `reqN_ready` is never high outside IDLE.
- Requests held valid while not granted keep their payload stable. The arbiter samples the payload only on the handshake cycle.
- A request arriving during EXEC or RESP waits. A response stall blocks both ports: there is one shared ALU slot and no queue.
- Simultaneous valid on both ports in consecutive IDLE visits produces strict alternation.

## Structure
- Shared package `alu_pkg`:
  - ctl bit-index constants and flag bit-index constants.
  - FSM state typedef (`ALU_ARB_IDLE`, `ALU_ARB_EXEC`, `ALU_ARB_RESP`).
  - `WIDTH` default.
- One natural sub-module, `rr_arbiter2`: combinational 2-way round-robin pick from valids and `prio`, returning a one-hot grant.
- The existing ALU is instantiated by the parent and not inside this block, so the bench can bind a real ALU or a stub.

## Test plan
- Single request on port 0 (rs=5, rt=3, ctl=4'b0000) with a real ALU:
  - `req0_ready` pulses in one cycle.
  - `rsp0_valid` rises 2 cycles later with result 8 and flags 4'b0000.
  - `rsp1_valid` stays 0.
- Both ports valid continuously with distinct operands, responses accepted at once:
  - Grants alternate 0, 1, 0, 1, each 3 cycles apart.
  - Each response carries its own port's result.
- Only port 1 valid, with `prio` pointing at port 1 after a port-0 grant: port 1 is granted immediately.
- `rsp0_ready` held low 5 cycles:
  - Result and flags stay stable and `busy` stays 1.
  - `req1_ready` stays 0 throughout.
  - On release, port 1 is granted in the first cycle back in IDLE.
- `rst_n` asserted asynchronously during EXEC:
  - All outputs return to their reset values immediately.
  - No response appears after release.
  - The next request is serviced normally with `prio`=0.
- `alu_*` check: across a grant with ctl=4'b1000 and imm=0x0000_00FF, the ALU inputs change only in the cycle after the handshake and hold through RESP.
